f2i_pipe: RTL and testbench
===========================

# f2i_pipe

Parameterised, pipelined IEEE‑754 float‑to‑integer converter. It succeeds the single‑format fixed converter, adding:
- independent float and integer widths;
- all five IEEE rounding modes;
- saturating signed/unsigned results with invalid and inexact flags;
- a valid/tag pipeline with clock‑enable stall.

It sits in the FPU execute path beside the i2f/f2i units. It feeds the integer writeback and the FP status register.

## Interface
- FPWID, 48: float width. EXPWID, 11: exponent width. FMSB = FPWID-EXPWID-2.
- OWID, 48: integer result width, 8..128.
- TAGWID, 6: width of the opaque tag carried alongside each operand.
- clk  in  1  clock.
- rst  in  1  synchronous, active‑high reset.
- ce  in  1  clock enable. When low, every pipeline register holds.
- vld_i  in  1  operand valid.
- op  in  1  1 = signed result, 0 = unsigned.
- rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN (toward −inf), 3 RUP (toward +inf), 4 RMM. Codes 5–7 behave as RNE.
- i  in  FPWID  float operand.
- tag_i  in  TAGWID  passthrough tag.
- vld_o  out  1  result valid.
- o  out  OWID  integer result.
- tag_o  out  TAGWID  tag aligned with o.
- invalid  out  1  NaN, ±inf or out‑of‑range input.
- inexact  out  1  result differs from the exact input value (never set together with invalid).

## Operation
- Decode: bias = 2^(EXPWID-1)-1 and e = exp - bias.
  - exp==0 (zero or subnormal): magnitude is 0 and sticky = (frac!=0).
  - exp all‑ones: inf when frac==0, NaN otherwise.
- Shift: form {1,frac} scaled by 2^e into an OWID+1‑bit integer part plus a guard bit and a sticky bit (OR of all discarded bits).
  - e < -1: integer 0, guard 0, sticky 1.
  - e >= OWID+1: force overflow; no shifting.
- Round increment per rm, using the sign, integer LSB, guard (G) and sticky (S):
  - RNE: G&(S|LSB).
  - RTZ: 0.
  - RDN: sgn&(G|S).
  - RUP: ~sgn&(G|S).
  - RMM: G.
- Range check on the rounded magnitude M:
  - Signed: legal if M ≤ 2^(OWID-1)-1, or if sgn and M == 2^(OWID-1).
  - Unsigned: legal if M ≤ 2^OWID-1, and additionally M == 0 whenever sgn is set.
- Results:
  - NaN → signed 2^(OWID-1)-1, unsigned all‑ones, invalid=1.
  - +inf or positive overflow → signed 2^(OWID-1)-1, unsigned all‑ones, invalid=1.
  - −inf or negative overflow → signed −2^(OWID-1), unsigned 0, invalid=1.
  - Legal → o = sgn ? −M : M (two's complement, OWID bits); inexact = G|S.
- −0.0 and +0.0 → 0 with no flags.
- A negative input that rounds to 0 in unsigned mode → 0, with inexact only.

## Timing
- Three register stages (decode, shift/sticky, round/saturate). Latency is exactly 3 enabled cycles from vld_i to vld_o.
- Throughput is one operand per enabled cycle. There is no back‑pressure; the consumer stalls the unit with ce.
- ce low: all data, valid and tag registers hold; outputs are stable.
- Valid bits advance only on ce. vld_i sampled while ce is low is ignored.
- Bubbles (vld_i=0) propagate. Data in invalid stages is don't‑care, but o, invalid and inexact are forced to 0 whenever vld_o=0.
- rst has priority over ce.
  - On rst, all stage valids clear, so in‑flight operations are discarded.
  - Reset values: vld_o=0, o=0, tag_o=0, invalid=0, inexact=0.
  - The first operand accepted in the cycle after rst deasserts appears 3 enabled cycles later.
- op, rm and tag are captured together with i and travel with it. Mode changes between back‑to‑back operands take effect per operand.

## Test plan
Concrete values use defaults (fp48, bias 1023, OWID 48).
- **Rounding, positive:** i=0x400400000000 (2.5), op=1.
  - rm=RNE → o=2, inexact=1.
  - rm=RUP → 3.
  - rm=RMM → 3.
  - rm=RTZ → 2.
- **Rounding, negative:** i=0xC00400000000 (−2.5), op=1.
  - RDN → o=0xFFFFFFFFFFFD.
  - RNE → 0xFFFFFFFFFFFE.
- **RNE tie to even:** i=0x400C00000000 (3.5) → o=4.
- **Exact:** i=0x3FF000000000 (1.0) → 1, no flags.
- **Boundaries:**
  - i=0x42E000000000 (2^47), op=1 → 0x7FFFFFFFFFFF, invalid=1.
  - Same input, op=0 → 0x800000000000, no flags.
  - i=0xC2E000000000, op=1 → 0x800000000000, no flags.
  - i=0x7FF800000000 (NaN), op=0 → 0xFFFFFFFFFFFF, invalid=1.
- **Unsigned negatives:**
  - i=0xBFF000000000 (−1.0), op=0 → 0, invalid=1.
  - i=0xBFD000000000 (−0.25), op=0, RNE → 0, inexact=1, invalid=0.
- **Pipeline:**
  - Stream 5 operands with tags 1..5, with ce held low for 2 cycles mid‑stream → results in order with matching tags, outputs frozen during the stall.
  - Assert rst with 2 operations in flight → vld_o stays 0 and neither result appears.

Source files
------------

// File: rtl/f2i_pipe.sv
// Pipelined IEEE-754 float to integer converter with selectable rounding,
// signed/unsigned saturation, invalid/inexact flags and a valid/tag pipeline.
module f2i_pipe #(
  parameter int FPWID  = 48,
  parameter int EXPWID = 11,
  parameter int OWID   = 48,
  parameter int TAGWID = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              vld_i,
  input  logic              op,
  input  logic [2:0]        rm,
  input  logic [FPWID-1:0]  i,
  input  logic [TAGWID-1:0] tag_i,
  output logic              vld_o,
  output logic [OWID-1:0]   o,
  output logic [TAGWID-1:0] tag_o,
  output logic              invalid,
  output logic              inexact
);

  localparam int FMSB = FPWID - EXPWID - 2;
  localparam int FB   = FMSB + 1;          // fraction bits below the hidden one
  localparam int MW   = FMSB + 2;          // {1, frac}
  localparam int WW   = MW + OWID + 1;     // shifted mantissa, integer part is OWID+1 bits
  localparam int BIAS = (1 << (EXPWID - 1)) - 1;

  localparam logic [OWID+1:0] HALF = (OWID+2)'(1) << (OWID - 1);
  localparam logic [OWID+1:0] UMAX = ((OWID+2)'(1) << OWID) - 1;
  localparam logic [OWID-1:0] SMAX = {1'b0, {(OWID-1){1'b1}}};
  localparam logic [OWID-1:0] SMIN = {1'b1, {(OWID-1){1'b0}}};

  // ---------------- stage 1: decode ----------------
  logic [EXPWID-1:0]       exp_f;
  logic [FMSB:0]           frac_f;
  logic signed [EXPWID:0]  e_next;

  always_comb begin
    exp_f  = i[FPWID-2 -: EXPWID];
    frac_f = i[FMSB:0];
    e_next = (EXPWID+1)'(int'({1'b0, exp_f}) - BIAS);
  end

  logic                   v1_reg, sgn1_reg, op1_reg;
  logic [2:0]             rm1_reg;
  logic [TAGWID-1:0]      tag1_reg;
  logic signed [EXPWID:0] e1_reg;
  logic [MW-1:0]          mant1_reg;
  logic                   zero1_reg, fnz1_reg, nan1_reg, inf1_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      sgn1_reg  <= 1'b0;
      op1_reg   <= 1'b0;
      rm1_reg   <= '0;
      tag1_reg  <= '0;
      e1_reg    <= '0;
      mant1_reg <= '0;
      zero1_reg <= 1'b0;
      fnz1_reg  <= 1'b0;
      nan1_reg  <= 1'b0;
      inf1_reg  <= 1'b0;
    end else if (ce) begin
      v1_reg    <= vld_i;
      sgn1_reg  <= i[FPWID-1];
      op1_reg   <= op;
      rm1_reg   <= rm;
      tag1_reg  <= tag_i;
      e1_reg    <= e_next;
      mant1_reg <= {1'b1, frac_f};
      zero1_reg <= (exp_f == '0);
      fnz1_reg  <= |frac_f;
      nan1_reg  <= (&exp_f) & (|frac_f);
      inf1_reg  <= (&exp_f) & ~(|frac_f);
    end
  end

  // ---------------- stage 2: shift, guard, sticky ----------------
  int              e_int;
  logic [7:0]      shamt;
  logic [WW-1:0]   wide;
  logic [OWID:0]   int_next;
  logic            g_next, s_next, ovf_next;

  always_comb begin
    e_int    = int'(e1_reg);
    shamt    = 8'(e_int + 1);
    wide     = WW'(mant1_reg) << shamt;
    int_next = '0;
    g_next   = 1'b0;
    s_next   = 1'b0;
    ovf_next = 1'b0;
    if (zero1_reg) begin
      s_next = fnz1_reg;
    end else if (e_int < -1) begin
      s_next = 1'b1;
    end else if (e_int >= OWID + 1) begin
      ovf_next = 1'b1;
    end else begin
      // value*2 = mant << (e+1); point sits FB+1 bits up, guard just below it
      int_next = wide[WW-1:FB+1];
      g_next   = wide[FB];
      s_next   = |wide[FB-1:0];
    end
  end

  logic              v2_reg, sgn2_reg, op2_reg;
  logic [2:0]        rm2_reg;
  logic [TAGWID-1:0] tag2_reg;
  logic [OWID:0]     int2_reg;
  logic              g2_reg, s2_reg, ovf2_reg, nan2_reg, inf2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_reg   <= 1'b0;
      sgn2_reg <= 1'b0;
      op2_reg  <= 1'b0;
      rm2_reg  <= '0;
      tag2_reg <= '0;
      int2_reg <= '0;
      g2_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      ovf2_reg <= 1'b0;
      nan2_reg <= 1'b0;
      inf2_reg <= 1'b0;
    end else if (ce) begin
      v2_reg   <= v1_reg;
      sgn2_reg <= sgn1_reg;
      op2_reg  <= op1_reg;
      rm2_reg  <= rm1_reg;
      tag2_reg <= tag1_reg;
      int2_reg <= int_next;
      g2_reg   <= g_next;
      s2_reg   <= s_next;
      ovf2_reg <= ovf_next;
      nan2_reg <= nan1_reg;
      inf2_reg <= inf1_reg;
    end
  end

  // ---------------- stage 3: round and saturate ----------------
  logic              inc, legal;
  logic [OWID+1:0]   m;
  logic [OWID-1:0]   mag, o_next;
  logic              inv_next, inx_next;

  always_comb begin
    case (rm2_reg)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sgn2_reg & (g2_reg | s2_reg);
      3'd3:    inc = ~sgn2_reg & (g2_reg | s2_reg);
      3'd4:    inc = g2_reg;
      default: inc = g2_reg & (s2_reg | int2_reg[0]);
    endcase
    m   = {1'b0, int2_reg} + (OWID+2)'(inc);
    mag = m[OWID-1:0];
    if (op2_reg) legal = (m < HALF) || (sgn2_reg && (m == HALF));
    else         legal = (m <= UMAX) && (!sgn2_reg || (m == '0));

    o_next   = '0;
    inv_next = 1'b0;
    inx_next = 1'b0;
    if (v2_reg) begin
      if (nan2_reg || ((inf2_reg || ovf2_reg || !legal) && !sgn2_reg)) begin
        o_next   = op2_reg ? SMAX : '1;
        inv_next = 1'b1;
      end else if (inf2_reg || ovf2_reg || !legal) begin
        o_next   = op2_reg ? SMIN : '0;
        inv_next = 1'b1;
      end else begin
        o_next   = sgn2_reg ? (~mag + 1'b1) : mag;
        inx_next = g2_reg | s2_reg;
      end
    end
  end

  logic              v3_reg, inv3_reg, inx3_reg;
  logic [OWID-1:0]   o3_reg;
  logic [TAGWID-1:0] tag3_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      v3_reg   <= 1'b0;
      o3_reg   <= '0;
      tag3_reg <= '0;
      inv3_reg <= 1'b0;
      inx3_reg <= 1'b0;
    end else if (ce) begin
      v3_reg   <= v2_reg;
      o3_reg   <= o_next;
      tag3_reg <= tag2_reg;
      inv3_reg <= inv_next;
      inx3_reg <= inx_next;
    end
  end

  assign vld_o   = v3_reg;
  assign o       = o3_reg;
  assign tag_o   = tag3_reg;
  assign invalid = inv3_reg;
  assign inexact = inx3_reg;

endmodule

// File: tb/tb_f2i_pipe.sv
// Self-checking bench for f2i_pipe: directed spec vectors plus randomized
// streams with ce stalls, checked against a real-arithmetic reference model.
module tb_f2i_pipe;

  logic        clk = 1'b0;
  logic        rst, ce, vld_i, op;
  logic [2:0]  rm;
  logic [47:0] i;
  logic [5:0]  tag_i;
  logic        vld_o, invalid, inexact;
  logic [47:0] o;
  logic [5:0]  tag_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int en_cnt = 0;

  typedef struct packed {logic [47:0] o; logic inv; logic inx;} res_t;
  typedef struct packed {res_t r; logic [5:0] tag; int cnt;} exp_t;
  exp_t exp_q[$];

  typedef struct packed {
    logic [47:0] x; logic sop; logic [2:0] rm; logic [47:0] eo; logic einv; logic einx;
  } vec_t;
  localparam int ND = 21;
  vec_t dv [ND] = '{
    '{48'h400400000000, 1'b1, 3'd0, 48'd2,            1'b0, 1'b1},
    '{48'h400400000000, 1'b1, 3'd3, 48'd3,            1'b0, 1'b1},
    '{48'h400400000000, 1'b1, 3'd4, 48'd3,            1'b0, 1'b1},
    '{48'h400400000000, 1'b1, 3'd1, 48'd2,            1'b0, 1'b1},
    '{48'hC00400000000, 1'b1, 3'd2, 48'hFFFFFFFFFFFD, 1'b0, 1'b1},
    '{48'hC00400000000, 1'b1, 3'd0, 48'hFFFFFFFFFFFE, 1'b0, 1'b1},
    '{48'h400C00000000, 1'b1, 3'd0, 48'd4,            1'b0, 1'b1},
    '{48'h3FF000000000, 1'b1, 3'd0, 48'd1,            1'b0, 1'b0},
    '{48'h42E000000000, 1'b1, 3'd0, 48'h7FFFFFFFFFFF, 1'b1, 1'b0},
    '{48'h42E000000000, 1'b0, 3'd0, 48'h800000000000, 1'b0, 1'b0},
    '{48'hC2E000000000, 1'b1, 3'd0, 48'h800000000000, 1'b0, 1'b0},
    '{48'h7FF800000000, 1'b0, 3'd0, 48'hFFFFFFFFFFFF, 1'b1, 1'b0},
    '{48'hBFF000000000, 1'b0, 3'd0, 48'd0,            1'b1, 1'b0},
    '{48'hBFD000000000, 1'b0, 3'd0, 48'd0,            1'b0, 1'b1},
    '{48'h800000000000, 1'b1, 3'd0, 48'd0,            1'b0, 1'b0},
    '{48'h7FF000000000, 1'b1, 3'd0, 48'h7FFFFFFFFFFF, 1'b1, 1'b0},
    '{48'hFFF000000000, 1'b1, 3'd0, 48'h800000000000, 1'b1, 1'b0},
    '{48'h000000000001, 1'b1, 3'd3, 48'd1,            1'b0, 1'b1},
    '{48'h400400000000, 1'b1, 3'd5, 48'd2,            1'b0, 1'b1},
    '{48'h400C00000000, 1'b1, 3'd7, 48'd4,            1'b0, 1'b1},
    '{48'hC00400000000, 1'b1, 3'd4, 48'hFFFFFFFFFFFD, 1'b0, 1'b1}
  };

  always #5 clk = ~clk;

  f2i_pipe dut (
    .clk(clk), .rst(rst), .ce(ce), .vld_i(vld_i), .op(op), .rm(rm), .i(i), .tag_i(tag_i),
    .vld_o(vld_o), .o(o), .tag_o(tag_o), .invalid(invalid), .inexact(inexact)
  );

  // Reference: exact real value, floor + remainder, then the rounding rule.
  function automatic res_t model(input logic [47:0] x, input logic sop, input logic [2:0] r);
    logic sgn, up, legal;
    int ex;
    longint fr, mag;
    real a, fl, rem, m;
    res_t res;
    sgn = x[47];
    ex  = int'(x[46:36]);
    fr  = longint'(x[35:0]);
    res = '0;
    if (ex == 2047) begin
      if (fr != 0 || !sgn) res.o = sop ? 48'h7FFFFFFFFFFF : 48'hFFFFFFFFFFFF;
      else                 res.o = sop ? 48'h800000000000 : 48'h0;
      res.inv = 1'b1;
      return res;
    end
    if (ex == 0) begin
      fl  = 0.0;
      rem = (fr != 0) ? 0.25 : 0.0;
    end else begin
      a   = (1.0 + real'(fr) / (2.0 ** 36)) * (2.0 ** (ex - 1023));
      fl  = $floor(a);
      rem = a - fl;
    end
    case (r)
      3'd1:    up = 1'b0;
      3'd2:    up = sgn && rem > 0.0;
      3'd3:    up = !sgn && rem > 0.0;
      3'd4:    up = rem >= 0.5;
      default: up = rem > 0.5 || (rem == 0.5 && $floor(fl / 2.0) * 2.0 != fl);
    endcase
    m = up ? fl + 1.0 : fl;
    if (sop) legal = (m <= 2.0 ** 47 - 1.0) || (sgn && m == 2.0 ** 47);
    else     legal = (m <= 2.0 ** 48 - 1.0) && (!sgn || m == 0.0);
    if (!legal) begin
      if (sgn) res.o = sop ? 48'h800000000000 : 48'h0;
      else     res.o = sop ? 48'h7FFFFFFFFFFF : 48'hFFFFFFFFFFFF;
      res.inv = 1'b1;
    end else begin
      mag     = longint'(m);
      res.o   = sgn ? 48'(-mag) : 48'(mag);
      res.inx = rem > 0.0;
    end
    return res;
  endfunction

  function automatic logic [47:0] rand_fp();
    logic [63:0] t;
    logic [35:0] fr, msk;
    logic [10:0] ex;
    int sel;
    t   = {$urandom(), $urandom()};
    fr  = t[35:0];
    sel = int'($urandom_range(0, 15));
    if (sel == 0)      ex = 11'd0;
    else if (sel == 1) ex = 11'h7FF;
    else if (sel == 2) ex = 11'(1023 + $urandom_range(46, 60));
    else               ex = 11'(1021 + $urandom_range(0, 50));
    if ($urandom_range(0, 2) == 0) begin
      msk = 36'hFFFFFFFFF << $urandom_range(20, 35);
      fr  = fr & msk;
    end
    if (sel == 1 && $urandom_range(0, 1) == 0) fr = '0;
    return {1'($urandom_range(0, 1)), ex, fr};
  endfunction

  // Drive one cycle; record accepted operands with their expected result.
  task automatic step(input logic c, input logic v, input logic [47:0] x,
                      input logic s_op, input logic [2:0] r, input logic [5:0] t);
    exp_t it;
    ce = c; vld_i = v; i = x; op = s_op; rm = r; tag_i = t;
    @(posedge clk);
    if (c && !rst) begin
      en_cnt++;
      if (v) begin
        it.r = model(x, s_op, r); it.tag = t; it.cnt = en_cnt;
        exp_q.push_back(it);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp += 5;
    if (vld_o !== 1'b0)    begin n_fail++; $display("FAIL reset_vld got=%b exp=0", vld_o); end
    if (o !== 48'h0)       begin n_fail++; $display("FAIL reset_o got=%h exp=0", o); end
    if (tag_o !== 6'h0)    begin n_fail++; $display("FAIL reset_tag got=%h exp=0", tag_o); end
    if (invalid !== 1'b0)  begin n_fail++; $display("FAIL reset_invalid got=%b exp=0", invalid); end
    if (inexact !== 1'b0)  begin n_fail++; $display("FAIL reset_inexact got=%b exp=0", inexact); end
  endtask

  task automatic test_directed();
    int k;
    exp_t e;
    k = 0;
    for (int n = 0; n < ND + 6; n++) begin
      if (n < ND) step(1'b1, 1'b1, dv[n].x, dv[n].sop, dv[n].rm, 6'(n));
      else        step(1'b1, 1'b0, 48'h0, 1'b0, 3'd0, 6'd0);
      if (vld_o) begin
        e = exp_q.pop_front();
        n_cmp += 2;
        if (k >= ND) begin
          n_fail++; $display("FAIL directed_extra got tag=%0d exp=none", tag_o);
        end else begin
          $display("directed tag=%0d o=%h inv=%b inx=%b", tag_o, o, invalid, inexact);
          if ({o, invalid, inexact, tag_o} !== {dv[k].eo, dv[k].einv, dv[k].einx, 6'(k)}) begin
            n_fail++;
            $display("FAIL directed_%0d got o=%h inv=%b inx=%b tag=%0d exp o=%h inv=%b inx=%b tag=%0d",
                     k, o, invalid, inexact, tag_o, dv[k].eo, dv[k].einv, dv[k].einx, k);
          end
        end
        if (en_cnt - e.cnt !== 2) begin
          n_fail++; $display("FAIL directed_latency got=%0d exp=2", en_cnt - e.cnt);
        end
        k++;
      end
    end
    n_cmp++;
    if (k !== ND) begin n_fail++; $display("FAIL directed_count got=%0d exp=%0d", k, ND); end
  endtask

  task automatic test_random();
    exp_t e;
    logic c, v;
    logic [61:0] prev;
    prev = {vld_o, o, tag_o, invalid, inexact};
    for (int n = 0; n < 406; n++) begin
      c = (n >= 400) || ($urandom_range(0, 3) != 0);
      v = (n < 400) && ($urandom_range(0, 4) != 0);
      step(c, v, rand_fp(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           6'($urandom_range(0, 63)));
      n_cmp++;
      if (!c) begin
        if ({vld_o, o, tag_o, invalid, inexact} !== prev) begin
          n_fail++; $display("FAIL random_hold got=%h exp=%h", {vld_o, o, tag_o, invalid, inexact}, prev);
        end
      end else if (vld_o) begin
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL random_spurious got tag=%0d exp=none", tag_o);
        end else begin
          e = exp_q.pop_front();
          $display("random tag=%0d o=%h inv=%b inx=%b", tag_o, o, invalid, inexact);
          if ({o, invalid, inexact, tag_o} !== {e.r, e.tag} || en_cnt - e.cnt !== 2) begin
            n_fail++;
            $display("FAIL random_result got o=%h inv=%b inx=%b tag=%0d lat=%0d exp o=%h inv=%b inx=%b tag=%0d lat=2",
                     o, invalid, inexact, tag_o, en_cnt - e.cnt, e.r.o, e.r.inv, e.r.inx, e.tag);
          end
        end
      end else if ({o, invalid, inexact} !== '0) begin
        n_fail++; $display("FAIL random_idle_zero got o=%h inv=%b inx=%b exp 0", o, invalid, inexact);
      end
      prev = {vld_o, o, tag_o, invalid, inexact};
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL random_drain got=%0d pending exp=0", exp_q.size());
    end
  endtask

  task automatic test_pipeline();
    exp_t e;
    logic c;
    logic [61:0] prev;
    int nxt;
    nxt = 1;
    prev = {vld_o, o, tag_o, invalid, inexact};
    for (int n = 0; n < 12; n++) begin
      c = !(n == 3 || n == 4);
      if (!c)           step(1'b0, 1'b1, rand_fp(), 1'b1, 3'd0, 6'd63);
      else if (nxt <= 5) begin
        step(1'b1, 1'b1, rand_fp(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), 6'(nxt));
        nxt++;
      end else          step(1'b1, 1'b0, 48'h0, 1'b0, 3'd0, 6'd0);
      n_cmp++;
      if (!c) begin
        if ({vld_o, o, tag_o, invalid, inexact} !== prev) begin
          n_fail++; $display("FAIL pipe_stall_hold got=%h exp=%h", {vld_o, o, tag_o, invalid, inexact}, prev);
        end
      end else if (vld_o) begin
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL pipe_spurious got tag=%0d exp=none", tag_o);
        end else begin
          e = exp_q.pop_front();
          $display("pipeline tag=%0d o=%h inv=%b inx=%b", tag_o, o, invalid, inexact);
          if ({o, invalid, inexact, tag_o} !== {e.r, e.tag} || en_cnt - e.cnt !== 2) begin
            n_fail++;
            $display("FAIL pipe_result got o=%h inv=%b inx=%b tag=%0d lat=%0d exp o=%h inv=%b inx=%b tag=%0d lat=2",
                     o, invalid, inexact, tag_o, en_cnt - e.cnt, e.r.o, e.r.inv, e.r.inx, e.tag);
          end
        end
      end
      prev = {vld_o, o, tag_o, invalid, inexact};
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL pipe_drain got=%0d pending exp=0", exp_q.size());
    end
  endtask

  task automatic test_flush();
    exp_t e;
    logic seen;
    step(1'b1, 1'b1, 48'h3FF000000000, 1'b1, 3'd0, 6'd11);
    step(1'b1, 1'b1, 48'h400400000000, 1'b1, 3'd0, 6'd12);
    rst = 1'b1;
    step(1'b0, 1'b0, 48'h0, 1'b0, 3'd0, 6'd0);
    rst = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 6; n++) begin
      step(1'b1, 1'b0, 48'h0, 1'b0, 3'd0, 6'd0);
      n_cmp++;
      if (vld_o !== 1'b0) begin
        n_fail++; $display("FAIL flush_vld got=%b tag=%0d exp=0", vld_o, tag_o);
      end
    end
    seen = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step(1'b1, n == 0, 48'h400C00000000, 1'b1, 3'd0, 6'd21);
      if (vld_o && !seen) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        n_cmp++;
        $display("flush tag=%0d o=%h inv=%b inx=%b", tag_o, o, invalid, inexact);
        if ({o, invalid, inexact, tag_o} !== {48'd4, 1'b0, 1'b1, 6'd21} || en_cnt - e.cnt !== 2) begin
          n_fail++;
          $display("FAIL flush_after got o=%h inv=%b inx=%b tag=%0d lat=%0d exp o=4 inv=0 inx=1 tag=21 lat=2",
                   o, invalid, inexact, tag_o, en_cnt - e.cnt);
        end
      end
    end
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL flush_timeout got=none exp=tag 21"); end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; vld_i = 1'b0; op = 1'b0; rm = 3'd0; i = '0; tag_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_directed();
    test_pipeline();
    test_random();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
